// File: rtl/ca_code_nco.sv
// ca_code_nco: chipping-rate NCO that paces the C/A code generator.
// It counts chips modulo CHIPS, flags the code epoch, supports chip slew,
// taps early/prompt/late replicas at half-chip spacing and snapshots the
// code phase on request.
module ca_code_nco #(
    parameter int unsigned NCO_W   = 32,
    parameter int unsigned CHIPS   = 1023,
    parameter int unsigned PH_FRAC = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NCO_W-1:0]      code_rate,
    input  logic                  rate_load,
    input  logic                  slew_req,
    input  logic [9:0]            slew_chips,
    input  logic                  phase_latch,
    input  logic                  chip_in,
    output logic                  ca_en,
    output logic [9:0]            chip_cnt,
    output logic                  epoch,
    output logic                  early,
    output logic                  prompt,
    output logic                  late,
    output logic                  slew_busy,
    output logic                  slew_done,
    output logic [10+PH_FRAC-1:0] code_phase
);

    localparam int unsigned CNT_W = 10;
    localparam logic [NCO_W-1:0] RATE_MAX  = {1'b0, {(NCO_W-1){1'b1}}};
    localparam logic [CNT_W-1:0] LAST_CHIP = CNT_W'(CHIPS - 1);

    typedef enum logic {
        SLEW_IDLE = 1'b0,
        SLEW_RUN  = 1'b1
    } slew_state_t;

    logic [NCO_W-1:0] rate;
    logic [NCO_W-1:0] acc;
    logic [NCO_W:0]   sum;
    logic             carry_q;
    logic             half_q;
    logic [2:0]       sr;
    logic [CNT_W-1:0] rem;
    slew_state_t      slew_st;
    logic             advance;

    // Accumulator add with carry-out; the carry marks a chip boundary.
    assign sum = {1'b0, acc} + {1'b0, rate};

    // A chip boundary advances the generator unless a slew is withholding it.
    assign advance = carry_q & ~slew_busy;
    assign ca_en   = advance;
    assign epoch   = advance & (chip_cnt == LAST_CHIP);

    assign slew_busy = (slew_st == SLEW_RUN);
    assign early     = sr[0];
    assign prompt    = sr[1];
    assign late      = sr[2];

    // Rate register; clamped below half scale so at most one half-chip event per clk.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rate <= '0;
        end else if (rate_load) begin
            rate <= code_rate[NCO_W-1] ? RATE_MAX : code_rate;
        end
    end

    // Phase accumulator plus registered chip-boundary and half-chip event flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc     <= '0;
            carry_q <= 1'b0;
            half_q  <= 1'b0;
        end else begin
            acc     <= sum[NCO_W-1:0];
            carry_q <= sum[NCO_W];
            half_q  <= sum[NCO_W] | (~acc[NCO_W-1] & sum[NCO_W-1]);
        end
    end

    // Chip index, updated together with ca_en and wrapping at the epoch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chip_cnt <= '0;
        end else if (advance) begin
            chip_cnt <= (chip_cnt == LAST_CHIP) ? '0 : chip_cnt + CNT_W'(1);
        end
    end

    // Slew controller: withholds a number of chip advances, then pulses done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slew_st   <= SLEW_IDLE;
            rem       <= '0;
            slew_done <= 1'b0;
        end else begin
            slew_done <= 1'b0;
            case (slew_st)
                SLEW_IDLE: begin
                    if (slew_req) begin
                        rem <= slew_chips;
                        if (slew_chips == '0) begin
                            slew_done <= 1'b1;
                        end else begin
                            slew_st <= SLEW_RUN;
                        end
                    end
                end
                SLEW_RUN: begin
                    if (carry_q) begin
                        rem <= rem - CNT_W'(1);
                        if (rem == CNT_W'(1)) begin
                            slew_st   <= SLEW_IDLE;
                            slew_done <= 1'b1;
                        end
                    end
                end
                default: slew_st <= SLEW_IDLE;
            endcase
        end
    end

    // Half-chip spaced replica shift register fed by the generator chip.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr <= '0;
        end else if (half_q) begin
            sr <= {sr[1:0], chip_in};
        end
    end

    // Code-phase snapshot of the pre-update chip index and fractional phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            code_phase <= '0;
        end else if (phase_latch) begin
            code_phase <= {chip_cnt, acc[NCO_W-1 -: PH_FRAC]};
        end
    end

endmodule

// File: tb/tb_ca_code_nco.sv
// tb_ca_code_nco: directed and randomized stimulus against an arithmetic
// model of the code NCO, with a PRN 1 C/A generator driving chip_in.
module tb_ca_code_nco;

    localparam int unsigned NCO_W   = 32;
    localparam int unsigned CHIPS   = 1023;
    localparam int unsigned PH_FRAC = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] code_rate;
    logic        rate_load;
    logic        slew_req;
    logic [9:0]  slew_chips;
    logic        phase_latch;
    logic        chip_in;
    logic        ca_en;
    logic [9:0]  chip_cnt;
    logic        epoch;
    logic        early;
    logic        prompt;
    logic        late;
    logic        slew_busy;
    logic        slew_done;
    logic [15:0] code_phase;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // Reference model state
    longint unsigned m_total;
    logic [31:0]     m_rate;
    bit              m_carry;
    bit              m_h;
    longint unsigned m_chips;
    int unsigned     m_withhold;
    bit              m_done;
    logic [15:0]     m_phase;
    bit              m_q[$];
    logic [10:1]     g1;
    logic [10:1]     g2;
    bit              gen_adv;

    ca_code_nco #(
        .NCO_W(NCO_W), .CHIPS(CHIPS), .PH_FRAC(PH_FRAC)
    ) dut (
        .clk(clk), .rst(rst), .code_rate(code_rate), .rate_load(rate_load),
        .slew_req(slew_req), .slew_chips(slew_chips), .phase_latch(phase_latch),
        .chip_in(chip_in), .ca_en(ca_en), .chip_cnt(chip_cnt), .epoch(epoch),
        .early(early), .prompt(prompt), .late(late), .slew_busy(slew_busy),
        .slew_done(slew_done), .code_phase(code_phase)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit q_at(input int back);
        if (m_q.size() > back) return m_q[m_q.size() - 1 - back];
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_total    = 0;
        m_rate     = '0;
        m_carry    = 1'b0;
        m_h        = 1'b0;
        m_chips    = 0;
        m_withhold = 0;
        m_done     = 1'b0;
        m_phase    = '0;
        m_q.delete();
        g1         = '1;
        g2         = '1;
        gen_adv    = 1'b0;
        chip_in    = g1[10] ^ g2[2] ^ g2[6];
    endtask

    // Advance the model across one clock edge using the inputs of the ending cycle.
    task automatic model_step();
        longint unsigned nxt;
        bit en;
        en      = m_carry && (m_withhold == 0);
        gen_adv = en;
        if (m_h) begin
            m_q.push_back(chip_in);
            if (m_q.size() > 3) void'(m_q.pop_front());
        end
        if (phase_latch) m_phase = {10'(m_chips % CHIPS), m_total[31:26]};
        if (en) m_chips++;
        m_done = 1'b0;
        if (m_withhold != 0) begin
            if (m_carry) begin
                m_withhold--;
                if (m_withhold == 0) m_done = 1'b1;
            end
        end else if (slew_req) begin
            m_withhold = 32'(slew_chips);
            m_done     = (slew_chips == 10'd0);
        end
        nxt     = m_total + 64'(m_rate);
        m_carry = (nxt >> 32) != (m_total >> 32);
        m_h     = (nxt >> 31) != (m_total >> 31);
        m_total = nxt;
        if (rate_load) m_rate = code_rate[31] ? 32'h7FFF_FFFF : code_rate;
    endtask

    task automatic gen_update();
        logic f1;
        logic f2;
        if (gen_adv) begin
            f1 = g1[3] ^ g1[10];
            f2 = g2[2] ^ g2[3] ^ g2[6] ^ g2[8] ^ g2[9] ^ g2[10];
            g1 = {g1[9:1], f1};
            g2 = {g2[9:1], f2};
        end
        gen_adv = 1'b0;
        chip_in = g1[10] ^ g2[2] ^ g2[6];
    endtask

    task automatic check_all();
        bit exp_en;
        exp_en = m_carry && (m_withhold == 0);
        check("ca_en",      32'(ca_en),      32'(exp_en));
        check("epoch",      32'(epoch),      32'(exp_en && ((m_chips % CHIPS) == CHIPS - 1)));
        check("chip_cnt",   32'(chip_cnt),   32'(m_chips % CHIPS));
        check("early",      32'(early),      32'(q_at(0)));
        check("prompt",     32'(prompt),     32'(q_at(1)));
        check("late",       32'(late),       32'(q_at(2)));
        check("slew_busy",  32'(slew_busy),  32'(m_withhold != 0));
        check("slew_done",  32'(slew_done),  32'(m_done));
        check("code_phase", 32'(code_phase), 32'(m_phase));
    endtask

    // One clock: model steps on the edge, outputs compared on the falling edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        gen_update();
        check_all();
        rate_load   = 1'b0;
        slew_req    = 1'b0;
        phase_latch = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ca_en"},      32'(ca_en),      32'd0);
        check({tag, "_epoch"},      32'(epoch),      32'd0);
        check({tag, "_chip_cnt"},   32'(chip_cnt),   32'd0);
        check({tag, "_epl"},        32'({early, prompt, late}), 32'd0);
        check({tag, "_slew_busy"},  32'(slew_busy),  32'd0);
        check({tag, "_slew_done"},  32'(slew_done),  32'd0);
        check({tag, "_code_phase"}, 32'(code_phase), 32'd0);
    endtask

    initial begin
        bit          found;
        bit          latched;
        bit          pl_pending;
        int unsigned busy_n;
        int unsigned done_n;
        int unsigned pick;

        rst         = 1'b0;
        code_rate   = '0;
        rate_load   = 1'b0;
        slew_req    = 1'b0;
        slew_chips  = '0;
        phase_latch = 1'b0;
        model_reset();

        // Reset state
        repeat (3) @(negedge clk);
        check_zero("reset");
        check_all();
        rst = 1'b1;

        // Zero rate: nothing moves
        repeat (20) tick();

        // Nominal rate, first epoch and phase snapshot at chip 511
        code_rate = 32'h4000_0000;
        rate_load = 1'b1;
        tick();
        found      = 1'b0;
        latched    = 1'b0;
        pl_pending = 1'b0;
        for (int i = 1; i <= 4200; i++) begin
            if (!latched && (m_chips % CHIPS) == 511 && m_total[31:0] == 32'h8000_0000) begin
                phase_latch = 1'b1;
                latched     = 1'b1;
                pl_pending  = 1'b1;
            end
            tick();
            if (pl_pending) begin
                check("phase_at_511", 32'(code_phase), 32'h0000_7FE0);
                pl_pending = 1'b0;
            end
            if (epoch) begin
                found = 1'b1;
                check("first_epoch_clks", 32'(i), 32'd4092);
                break;
            end
        end
        check("first_epoch_seen", 32'(found), 32'd1);
        check("phase_latch_done", 32'(latched), 32'd1);
        repeat (20) tick();

        // Slew of 5 chips issued on a chip-boundary cycle, second request ignored
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (m_carry && m_withhold == 0) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check("slew_align", 32'(found), 32'd1);
        slew_req   = 1'b1;
        slew_chips = 10'd5;
        tick();
        busy_n = 0;
        done_n = 0;
        for (int j = 0; j < 40; j++) begin
            if (slew_busy) busy_n++;
            if (slew_done) done_n++;
            if (j == 2) begin
                slew_req   = 1'b1;
                slew_chips = 10'd9;
            end
            tick();
        end
        check("slew5_busy_clks", busy_n, 32'd20);
        check("slew5_done_pulses", done_n, 32'd1);

        // Zero-chip slew
        slew_req   = 1'b1;
        slew_chips = 10'd0;
        tick();
        check("slew0_done", 32'(slew_done), 32'd1);
        check("slew0_busy", 32'(slew_busy), 32'd0);
        repeat (20) tick();

        // Clamped rate
        code_rate = 32'hC000_0000;
        rate_load = 1'b1;
        tick();
        check("rate_clamp", dut.rate, 32'h7FFF_FFFF);
        repeat (300) tick();

        // rate_load and slew_req in the same cycle
        code_rate  = 32'h4000_0000;
        rate_load  = 1'b1;
        slew_req   = 1'b1;
        slew_chips = 10'd3;
        tick();
        repeat (60) tick();

        // Randomized mix of rate loads, slews and phase latches
        for (int k = 0; k < 6000; k++) begin
            if ($urandom_range(0, 199) == 0) begin
                pick = $urandom_range(0, 3);
                case (pick)
                    0:       code_rate = $urandom;
                    1:       code_rate = $urandom >> 1;
                    2:       code_rate = $urandom >> 4;
                    default: code_rate = 32'h4000_0000;
                endcase
                rate_load = 1'b1;
            end
            if ($urandom_range(0, 99) == 0) begin
                slew_req   = 1'b1;
                slew_chips = 10'($urandom_range(0, 12));
            end
            if ($urandom_range(0, 49) == 0) phase_latch = 1'b1;
            tick();
        end

        // Asynchronous reset in the middle of a slew
        code_rate = 32'h4000_0000;
        rate_load = 1'b1;
        tick();
        repeat (37) tick();
        slew_req   = 1'b1;
        slew_chips = 10'd8;
        tick();
        repeat (10) tick();
        check("pre_reset_busy", 32'(slew_busy), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check_zero("async_reset");
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (40) tick();
        code_rate = 32'h4000_0000;
        rate_load = 1'b1;
        tick();
        repeat (300) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
